frame_write_scheduler: RTL

Sequences one frame of BRAM-sourced pixel data onto the AXI4-FULL write bus. Splits TOTAL_NUM 32-bit beats into INCR bursts of at most BURST_LEN beats, and drives the AW and B channels. Gates the BRAM-to-AXI data mover's `write_ready` so W beats only flow inside an issued burst, and generates WLAST. Sits between the game-frame control logic and the data mover / AXI interconnect.

---
 rtl/frame_write_scheduler_if.sv | 25 ++
 rtl/frame_write_scheduler.sv | 138 +++++++++++++
 2 files changed

// File: rtl/frame_write_scheduler_if.sv
// AXI4 write-address, write-data handshake and write-response signals
// between the frame write scheduler (master) and the interconnect (slave).
interface frame_write_scheduler_if;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic        wready;
  logic        wlast;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, wlast, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, wlast, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/frame_write_scheduler.sv
// Splits one frame of TOTAL_NUM 32-bit beats into INCR bursts of up to BURST_LEN
// beats, one burst outstanding at a time, gating the data mover's ready per burst.
module frame_write_scheduler #(
  parameter int TOTAL_NUM = 1536,
  parameter int BURST_LEN = 16
) (
  input  logic        axi_ACLK,
  input  logic        axi_ARESET,
  input  logic        frame_start,
  input  logic [31:0] frame_base,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic        mover_start,
  output logic        mover_ready,
  input  logic        mover_beat,
  frame_write_scheduler_if.master m_axi
);

  localparam int          ALIGN_BITS = $clog2(BURST_LEN * 4);
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ALIGN_BITS) - 32'd1);
  localparam logic [15:0] TOTAL16    = 16'(TOTAL_NUM);
  localparam logic [15:0] BURST16    = 16'(BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_DATA, S_RESP, S_DONE} state_t;

  state_t      state;
  logic [31:0] addr;
  logic [15:0] remaining;
  logic [8:0]  cur_len;
  logic [8:0]  beat_cnt;

  logic [15:0] remaining_after;
  logic [31:0] addr_after;
  logic        beat_ok;
  logic        last_beat;

  function automatic logic [8:0] min_len(input logic [15:0] rem);
    return (rem >= BURST16) ? 9'(BURST_LEN) : rem[8:0];
  endfunction

  function automatic logic [7:0] len_field(input logic [15:0] rem);
    logic [8:0] len;
    len = min_len(rem) - 9'd1;
    return len[7:0];
  endfunction

  assign m_axi.awsize    = 3'b010;
  assign m_axi.awburst   = 2'b01;

  // Beats only flow inside an issued burst; the mover sees wready only in DATA.
  assign mover_ready     = (state == S_DATA) && m_axi.wready;
  assign last_beat       = (beat_cnt == cur_len - 9'd1);
  assign m_axi.wlast     = (state == S_DATA) && last_beat;
  assign beat_ok         = (state == S_DATA) && mover_beat && m_axi.wready;
  assign remaining_after = remaining - {7'd0, cur_len};
  assign addr_after      = addr + {21'd0, cur_len, 2'b00};

  always_ff @(posedge axi_ACLK) begin
    if (axi_ARESET) begin
      state         <= S_IDLE;
      addr          <= '0;
      remaining     <= '0;
      cur_len       <= '0;
      beat_cnt      <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      mover_start   <= 1'b0;
      m_axi.awvalid <= 1'b0;
      m_axi.awaddr  <= '0;
      m_axi.awlen   <= '0;
      m_axi.bready  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            addr          <= frame_base & ALIGN_MASK;
            remaining     <= TOTAL16;
            cur_len       <= min_len(TOTAL16);
            frame_err     <= 1'b0;
            busy          <= 1'b1;
            mover_start   <= 1'b1;
            m_axi.awvalid <= 1'b1;
            m_axi.awaddr  <= frame_base & ALIGN_MASK;
            m_axi.awlen   <= len_field(TOTAL16);
            state         <= S_AW;
          end
        end
        S_AW: begin
          if (m_axi.awready) begin
            m_axi.awvalid <= 1'b0;
            beat_cnt      <= '0;
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_ok) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (last_beat) begin
              m_axi.bready <= 1'b1;
              state        <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (m_axi.bvalid) begin
            m_axi.bready <= 1'b0;
            remaining    <= remaining_after;
            addr         <= addr_after;
            if (m_axi.bresp[1]) begin
              frame_err <= 1'b1;
            end
            if (remaining_after == 16'd0) begin
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              // Next burst is computed from the post-response counters.
              cur_len       <= min_len(remaining_after);
              m_axi.awvalid <= 1'b1;
              m_axi.awaddr  <= addr_after;
              m_axi.awlen   <= len_field(remaining_after);
              state         <= S_AW;
            end
          end
        end
        S_DONE: begin
          frame_done  <= 1'b0;
          busy        <= 1'b0;
          mover_start <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
